// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter and sequencer for a shared 4:1 single-bit output line.
// Grants one requester at a time, drives a registered mux select and one-hot
// grant, and caps each tenure at HOLD_MAX cycles. A released grant hands over
// on the same edge, so there is no idle gap between grantees.
//
// Optional feature: define MUX4_ARB_LEDR_EN to add the registered LEDR debug
// port (grant, busy, z and sampled requests). Without it the port and its
// registers do not exist; all other behaviour is unchanged.

module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8    // legal range 1..255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [0:3] c,
   output logic       z,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       busy
`ifdef MUX4_ARB_LEDR_EN
   ,
   output logic [9:0] LEDR
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } arb_t;

   // Scan req from base upward with wrap; the first set bit wins.
   function automatic arb_t arbitrate(input logic [3:0] r, input logic [1:0] base);
      arb_t       res;
      logic [1:0] idx;
      res.found = 1'b0;
      res.idx   = base;
      for (int k = 0; k < 4; k++) begin
         idx = base + 2'(k);
         if (!res.found && r[idx]) begin
            res.found = 1'b1;
            res.idx   = idx;
         end
      end
      return res;
   endfunction

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] sel_nxt;
   logic [3:0] gnt_nxt;
   logic       busy_nxt;

   logic [1:0] arb_base;
   arb_t       arb;
   logic       release_now;

   // Arbitration base: after a release the requester just served drops to
   // lowest priority, otherwise the stored round-robin pointer is used.
   always_comb begin
      arb_base    = (state == GRANT) ? sel + 2'd1 : ptr;
      arb         = arbitrate(req, arb_base);
      release_now = !req[sel] || (cnt == 8'(HOLD_MAX - 1));
   end

   // Next-state and next-output logic for the two-state scheduler.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      sel_nxt   = sel;
      gnt_nxt   = gnt;
      busy_nxt  = busy;

      unique case (state)
         IDLE: begin
            if (arb.found) begin
               state_nxt = GRANT;
               sel_nxt   = arb.idx;
               gnt_nxt   = 4'b0001 << arb.idx;
               busy_nxt  = 1'b1;
               cnt_nxt   = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_nxt = sel + 2'd1;
               if (arb.found) begin
                  sel_nxt = arb.idx;
                  gnt_nxt = 4'b0001 << arb.idx;
                  cnt_nxt = 8'd0;
               end else begin
                  // sel keeps its last value while idle
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
                  busy_nxt  = 1'b0;
                  cnt_nxt   = 8'd0;
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over any release at that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state <= IDLE;
         ptr   <= 2'd0;
         cnt   <= 8'd0;
         sel   <= 2'd0;
         gnt   <= 4'b0000;
         busy  <= 1'b0;
         z     <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
         busy  <= busy_nxt;
         // z uses the pre-edge grant, so it trails the grant by one cycle
         z     <= busy ? c[sel] : 1'b0;
      end
   end

`ifdef MUX4_ARB_LEDR_EN
   // Debug LED mirror of the registered grant state plus sampled requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         LEDR <= 10'd0;
      end else begin
         LEDR <= {req, z, busy, gnt};
      end
   end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter. Three instances share the same inputs
// with HOLD_MAX = 8, 4 and 1 so timeout boundaries can be compared side by
// side. Inputs change 1 ns after the rising edge; outputs are checked there.

module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [0:3] c;

   logic       z8, z4, z1;
   logic [1:0] sel8, sel4, sel1;
   logic [3:0] gnt8, gnt4, gnt1;
   logic       busy8, busy4, busy1;
`ifdef MUX4_ARB_LEDR_EN
   logic [9:0] ledr8, ledr4, ledr1;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.HOLD_MAX(8)) dut8 (
      .clk(clk), .reset(reset), .req(req), .c(c),
      .z(z8), .sel(sel8), .gnt(gnt8), .busy(busy8)
`ifdef MUX4_ARB_LEDR_EN
      , .LEDR(ledr8)
`endif
   );

   mux4_rr_arbiter #(.HOLD_MAX(4)) dut4 (
      .clk(clk), .reset(reset), .req(req), .c(c),
      .z(z4), .sel(sel4), .gnt(gnt4), .busy(busy4)
`ifdef MUX4_ARB_LEDR_EN
      , .LEDR(ledr4)
`endif
   );

   mux4_rr_arbiter #(.HOLD_MAX(1)) dut1 (
      .clk(clk), .reset(reset), .req(req), .c(c),
      .z(z1), .sel(sel1), .gnt(gnt1), .busy(busy1)
`ifdef MUX4_ARB_LEDR_EN
      , .LEDR(ledr1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      step();
      step();
      reset = 1'b0;
   endtask

   // Safety net: the run is a fixed sequence, this only fires if time runs away.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e8, e4, e1;
      logic       ez8, ez1;

      // Reset held with all requests high: nothing may be granted.
      reset = 1'b1;
      req   = 4'b1111;
      c     = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("rst_gnt8_%0d", i),  32'(gnt8),  32'h0);
         check($sformatf("rst_busy8_%0d", i), 32'(busy8), 32'h0);
         check($sformatf("rst_z8_%0d", i),    32'(z8),    32'h0);
         check($sformatf("rst_sel8_%0d", i),  32'(sel8),  32'h0);
         check($sformatf("rst_gnt1_%0d", i),  32'(gnt1),  32'h0);
      end

      // Timeout rotation with all requests held; c[0]=1, c[2]=1.
      reset = 1'b0;
      c     = 4'b1010;
      for (int k = 0; k < 40; k++) begin
         step();
         e8  = 4'b0001 << ((k / 8) % 4);
         e4  = 4'b0001 << ((k / 4) % 4);
         e1  = 4'b0001 << (k % 4);
         ez8 = (k == 0) ? 1'b0 : (((((k - 1) / 8) % 4) % 2) == 0);
         ez1 = (k == 0) ? 1'b0 : ((((k - 1) % 4) % 2) == 0);
         check($sformatf("rot_gnt8_%0d", k),  32'(gnt8),  32'(e8));
         check($sformatf("rot_sel8_%0d", k),  32'(sel8),  32'((k / 8) % 4));
         check($sformatf("rot_busy8_%0d", k), 32'(busy8), 32'h1);
         check($sformatf("rot_z8_%0d", k),    32'(z8),    32'(ez8));
         check($sformatf("rot_gnt4_%0d", k),  32'(gnt4),  32'(e4));
         check($sformatf("rot_gnt1_%0d", k),  32'(gnt1),  32'(e1));
         check($sformatf("rot_z1_%0d", k),    32'(z1),    32'(ez1));
      end

      // Single requester 2 for three cycles, c[2]=1, then dropped.
      do_reset();
      req = 4'b0100;
      c   = 4'b0010;
      step();
      check("one_gnt8_a1", 32'(gnt8), 32'h4);
      check("one_busy8_a1", 32'(busy8), 32'h1);
      check("one_z8_a1", 32'(z8), 32'h0);
      step();
      check("one_gnt8_a2", 32'(gnt8), 32'h4);
      check("one_z8_a2", 32'(z8), 32'h1);
      step();
      check("one_gnt8_a3", 32'(gnt8), 32'h4);
      check("one_gnt4_a3", 32'(gnt4), 32'h4);
      check("one_gnt1_a3", 32'(gnt1), 32'h4);
      check("one_z8_a3", 32'(z8), 32'h1);
      req = 4'b0000;
      step();
      check("one_gnt8_a4", 32'(gnt8), 32'h0);
      check("one_busy8_a4", 32'(busy8), 32'h0);
      check("one_sel8_a4", 32'(sel8), 32'h2);
      check("one_z8_a4", 32'(z8), 32'h1);
      step();
      check("one_z8_a5", 32'(z8), 32'h0);
      check("one_gnt8_a5", 32'(gnt8), 32'h0);

      // Sole requester 1 across several HOLD_MAX=4 timeouts.
      do_reset();
      req = 4'b0010;
      c   = 4'b0000;
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("sole_gnt4_%0d", k),  32'(gnt4),  32'h2);
         check($sformatf("sole_busy4_%0d", k), 32'(busy4), 32'h1);
         check($sformatf("sole_gnt1_%0d", k),  32'(gnt1),  32'h2);
      end
      // Next edge is a timeout for dut4: pointer becomes 2, so 3 beats 0.
      req = 4'b1011;
      step();
      check("sole_next_gnt4", 32'(gnt4), 32'h8);
      check("sole_next_gnt8", 32'(gnt8), 32'h2);
      check("sole_next_gnt1", 32'(gnt1), 32'h8);

      // Wrap and priority around index 3.
      do_reset();
      req = 4'b1000;
      step();
      check("wrap_gnt8_a", 32'(gnt8), 32'h8);
      check("wrap_gnt1_a", 32'(gnt1), 32'h8);
      req = 4'b1001;
      step();
      check("wrap_gnt8_b", 32'(gnt8), 32'h8);
      check("wrap_gnt1_b", 32'(gnt1), 32'h1);
      req = 4'b0001;
      step();
      check("wrap_gnt8_c", 32'(gnt8), 32'h1);
      check("wrap_gnt1_c", 32'(gnt1), 32'h1);
      req = 4'b1000;
      step();
      check("wrap_gnt8_d", 32'(gnt8), 32'h8);
      check("wrap_gnt1_d", 32'(gnt1), 32'h8);

      // Reset in the middle of a grant.
      do_reset();
      c   = 4'b1111;
      req = 4'b0010;
      step();
      check("mrst_gnt8_a", 32'(gnt8), 32'h2);
      req = 4'b0100;
      step();
      check("mrst_gnt8_b", 32'(gnt8), 32'h4);
      reset = 1'b1;
      req   = 4'b1100;
      step();
      check("mrst_gnt8_rst", 32'(gnt8), 32'h0);
      check("mrst_busy8_rst", 32'(busy8), 32'h0);
      check("mrst_sel8_rst", 32'(sel8), 32'h0);
      check("mrst_z8_rst", 32'(z8), 32'h0);
      reset = 1'b0;
      step();
      check("mrst_gnt8_c", 32'(gnt8), 32'h4);
      req = 4'b1000;
      step();
      check("mrst_gnt8_d", 32'(gnt8), 32'h8);
      reset = 1'b1;
      req   = 4'b1001;
      step();
      check("mrst_gnt8_rst2", 32'(gnt8), 32'h0);
      reset = 1'b0;
      step();
      check("mrst_gnt8_e", 32'(gnt8), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
